// File: rtl/dptr_multiciclo_if.sv
// Instruction handshake, status and debug-read bundle for dptr_multiciclo.
interface dptr_multiciclo_if #(
    parameter int unsigned DATA_W = 32
);
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              busy;
    logic              done;
    logic              illegal;
    logic [DATA_W-1:0] result;
    logic              zf;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr_valid, instr, dbg_addr,
        input  instr_ready, busy, done, illegal, result, zf, dbg_data
    );

    modport slave (
        input  instr_valid, instr, dbg_addr,
        output instr_ready, busy, done, illegal, result, zf, dbg_data
    );
endinterface

// File: rtl/dptr_multiciclo.sv
// Multi-cycle MIPS subset datapath: R-type ALU ops, lw, sw through DECODE/EXEC/MEM/WB.
// Define DPTR_ADDI_EN to execute addi (op 0x08); otherwise addi is reported illegal.
module dptr_multiciclo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_N     = 32,
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    dptr_multiciclo_if.slave bus
);
    localparam int unsigned REG_W  = (REG_N > 1) ? $clog2(REG_N) : 1;
    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    logic [2:0]        r_state;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a, r_b, r_aluout, r_mdr, r_result;
    logic              r_zf;
    logic [DATA_W-1:0] r_rf  [REG_N];
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic [5:0]        w_op, w_funct;
    logic [REG_W-1:0]  w_rs, w_rt, w_rd, w_rf_waddr, w_dbg_idx;
    logic [DATA_W-1:0] w_imm_sext, w_alu_b, w_alu, w_rf_wdata;
    logic [MEM_AW-1:0] w_idx;
    logic              w_is_rtype, w_is_lw, w_is_sw, w_is_addi, w_legal, w_rf_we;

    assign w_op       = r_ir[31:26];
    assign w_funct    = r_ir[5:0];
    assign w_rs       = r_ir[21 +: REG_W];
    assign w_rt       = r_ir[16 +: REG_W];
    assign w_rd       = r_ir[11 +: REG_W];
    assign w_imm_sext = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};

    assign w_is_rtype = (w_op == OP_RTYPE) &&
                        ((w_funct == F_ADD) || (w_funct == F_SUB) || (w_funct == F_AND) ||
                         (w_funct == F_OR)  || (w_funct == F_NOR) || (w_funct == F_SLT));
    assign w_is_lw    = (w_op == OP_LW);
    assign w_is_sw    = (w_op == OP_SW);
`ifdef DPTR_ADDI_EN
    assign w_is_addi  = (w_op == OP_ADDI);
`else
    assign w_is_addi  = 1'b0;
`endif
    assign w_legal    = w_is_rtype || w_is_lw || w_is_sw || w_is_addi;

    // Non-R-type instructions all use the adder with the sign-extended immediate.
    assign w_alu_b = w_is_rtype ? r_b : w_imm_sext;

    always_comb begin
        w_alu = r_a + w_alu_b;
        if (w_is_rtype) begin
            case (w_funct)
                F_SUB:   w_alu = r_a - r_b;
                F_AND:   w_alu = r_a & r_b;
                F_OR:    w_alu = r_a | r_b;
                F_NOR:   w_alu = ~(r_a | r_b);
                F_SLT:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    assign w_idx      = r_aluout[2 +: MEM_AW];
    assign w_rf_waddr = w_is_rtype ? w_rd : w_rt;
    assign w_rf_wdata = w_is_lw ? r_mdr : r_aluout;
    assign w_rf_we    = (r_state == S_WB) && (w_rf_waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            r_result <= '0;
            r_zf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        r_ir    <= bus.instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_a     <= r_rf[w_rs];
                        r_b     <= r_rf[w_rt];
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_aluout <= w_alu;
                    r_result <= w_alu;
                    r_zf     <= (w_alu == '0);
                    r_state  <= (w_is_lw || w_is_sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (w_is_lw) begin
                        r_mdr    <= r_mem[w_idx];
                        r_result <= r_mem[w_idx];
                        r_state  <= S_WB;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_N); i++) r_rf[i] <= '0;
        end else if (w_rf_we) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) r_mem[i] <= '0;
        end else if ((r_state == S_MEM) && w_is_sw) begin
            r_mem[w_idx] <= r_b;
        end
    end

    assign w_dbg_idx       = bus.dbg_addr[REG_W-1:0];
    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.illegal     = (r_state == S_DECODE) && !w_legal;
    assign bus.done        = ((r_state == S_DECODE) && !w_legal) ||
                             ((r_state == S_MEM) && w_is_sw) || (r_state == S_WB);
    assign bus.result      = r_result;
    assign bus.zf          = r_zf;
    assign bus.dbg_data    = (w_dbg_idx == '0) ? '0 : r_rf[w_dbg_idx];
endmodule

// File: tb/tb_dptr_multiciclo.sv
// Randomised self-checking bench for dptr_multiciclo against an instruction-level model.
module tb_dptr_multiciclo;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_NOR = 6'h27, F_SLT = 6'h2A;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_ADDI = 6'h08;
`ifdef DPTR_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_result;
    logic        m_zf;

    dptr_multiciclo_if #(.DATA_W(32)) bus ();

    dptr_multiciclo #(.DATA_W(32), .REG_N(32), .MEM_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rd, input int rs, input int rt,
                                          input logic [5:0] fn);
        logic [4:0] d, s, t;
        d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0]; t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_result = '0;
        m_zf     = 1'b0;
    endtask

    // Architectural effect of one instruction; returns done latency and register to inspect.
    task automatic model_exec(input logic [31:0] ins, output int lat, output bit ill,
                              output int dst);
        logic [5:0]  op, fn;
        int          rs, rt, rd;
        logic [31:0] a, b, simm, r, addr;
        op = ins[31:26]; fn = ins[5:0];
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        a = m_rf[rs]; b = m_rf[rt]; simm = {{16{ins[15]}}, ins[15:0]};
        ill = 1'b0; dst = 0; lat = 3; r = '0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: r = a + b;
                6'h22: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h27: r = ~(a | b);
                6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: ill = 1'b1;
            endcase
            if (!ill) begin
                m_result = r; m_zf = (r == 0); dst = rd;
                if (rd != 0) m_rf[rd] = r;
            end
        end else if (op == OP_LW) begin
            addr = a + simm;
            r = m_mem[addr[7:2]];
            m_result = r; m_zf = (addr == 0); dst = rt; lat = 4;
            if (rt != 0) m_rf[rt] = r;
        end else if (op == OP_SW) begin
            addr = a + simm;
            m_mem[addr[7:2]] = b;
            m_result = addr; m_zf = (addr == 0);
        end else if (op == OP_ADDI && ADDI_EN) begin
            r = a + simm;
            m_result = r; m_zf = (r == 0); dst = rt;
            if (rt != 0) m_rf[rt] = r;
        end else begin
            ill = 1'b1;
        end
        if (ill) lat = 1;
    endtask

    // Issue one instruction; with hold, instr_valid stays high with a junk word while busy.
    task automatic issue(input logic [31:0] ins, input bit hold);
        int lat, dst, cyc;
        bit ill, seen;
        model_exec(ins, lat, ill, dst);
        cyc = 0;
        while (!bus.instr_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before_issue", {31'd0, bus.instr_ready}, 32'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) bus.instr = ~ins;
        else bus.instr_valid = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                seen = 1'b1;
                check("illegal_flag", {31'd0, bus.illegal}, {31'd0, ill});
                bus.instr_valid = 1'b0;
            end
        end
        check("done_cycle", cyc, lat);
        bus.dbg_addr = dst[4:0];
        @(negedge clk);
        check("done_single_pulse", {31'd0, bus.done}, 32'd0);
        check("ready_after", {31'd0, bus.instr_ready}, 32'd1);
        check("result", bus.result, m_result);
        check("zf", {31'd0, bus.zf}, {31'd0, m_zf});
        check("dbg_dest", bus.dbg_data, m_rf[dst]);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 32; i++) begin
            bus.dbg_addr = i[4:0];
            #1;
            check("regfile", bus.dbg_data, m_rf[i]);
        end
    endtask

    task automatic check_reg_const(input string tag, input int r, input logic [31:0] v);
        bus.dbg_addr = r[4:0];
        #1;
        check(tag, bus.dbg_data, v);
    endtask

    // Loads a small constant (or all-ones) into register r; without addi it is built from nor/add.
    task automatic set_reg(input int r, input logic [31:0] v);
        if (ADDI_EN) begin
            issue(itype(OP_ADDI, 0, r, v[15:0]), 1'b0);
        end else if (v == 32'hFFFF_FFFF) begin
            issue(rtype(r, 0, 0, F_NOR), 1'b0);
        end else begin
            issue(rtype(31, 0, 0, F_NOR), 1'b0);
            issue(rtype(30, 0, 31, F_SUB), 1'b0);
            issue(rtype(r, 0, 0, F_ADD), 1'b0);
            for (int b = 3; b >= 0; b--) begin
                issue(rtype(r, r, r, F_ADD), 1'b0);
                if (v[b]) issue(rtype(r, r, 30, F_ADD), 1'b0);
            end
        end
    endtask

    initial begin
        logic [5:0] fns [6];
        logic [5:0] bad_ops [5];
        logic [5:0] bad_fns [4];
        logic [31:0] ins;
        int k, rs, rt, rd;
        fns     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        bad_ops = '{6'h3F, 6'h01, 6'h02, 6'h04, 6'h0D};
        bad_fns = '{6'h00, 6'h21, 6'h26, 6'h2B};

        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.dbg_addr    = '0;
        model_reset();
        #2;
        check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check("rst_zf", {31'd0, bus.zf}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        set_reg(1, 32'd5);
        set_reg(2, 32'd7);
        issue(32'h0022_1820, 1'b0);
        check_reg_const("t1_r3", 3, 32'd12);
        check("t1_result", bus.result, 32'd12);

        issue(rtype(4, 1, 1, F_SUB), 1'b0);
        check_reg_const("t2_r4", 4, 32'd0);
        check("t2_zf", {31'd0, bus.zf}, 32'd1);
        issue(rtype(5, 1, 2, F_SLT), 1'b0);
        check_reg_const("t2_slt", 5, 32'd1);
        set_reg(1, 32'hFFFF_FFFF);
        issue(rtype(5, 2, 1, F_SLT), 1'b0);
        check_reg_const("t2_slt_rev", 5, 32'd0);
        issue(rtype(5, 1, 2, F_SLT), 1'b0);
        check_reg_const("t2_slt_signed", 5, 32'd1);

        issue(itype(OP_SW, 0, 2, 16'd8), 1'b0);
        issue(itype(OP_LW, 0, 6, 16'd8), 1'b0);
        check_reg_const("t3_r6", 6, 32'd7);
        check("t3_result", bus.result, 32'd7);
        issue(itype(OP_LW, 0, 7, 16'd264), 1'b0);
        check_reg_const("t3_wrap", 7, 32'd7);

        issue(32'hFC00_0000, 1'b0);
        issue(32'h0022_1800, 1'b0);
        issue(itype(OP_ADDI, 0, 9, 16'd99), 1'b0);
        check_regs();

        issue(rtype(8, 1, 2, F_ADD), 1'b1);
        issue(rtype(0, 2, 2, F_ADD), 1'b1);
        check_reg_const("t5_r0", 0, 32'd0);

        // Reset during the WB cycle of an add must cancel its register write.
        bus.instr       = rtype(12, 1, 2, F_ADD);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_done_in_wb", {31'd0, bus.done}, 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_ready", {31'd0, bus.instr_ready}, 32'd1);
        check("t6_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_done", {31'd0, bus.done}, 32'd0);
        check("t6_result", bus.result, 32'd0);
        check("t6_zf", {31'd0, bus.zf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_reg_const("t6_r12", 12, 32'd0);
        @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            k  = $urandom_range(0, 11);
            rs = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            rd = $urandom_range(0, 7);
            case (k)
                0, 1, 2, 3, 4: ins = rtype(rd, rs, rt, fns[$urandom_range(0, 5)]);
                5, 6:          ins = itype(OP_LW, rs, rt, 16'($urandom_range(0, 65535)));
                7:             ins = itype(OP_SW, rs, rt, 16'($urandom_range(0, 65535)));
                8, 9:          ins = itype(OP_ADDI, rs, rt, 16'($urandom_range(0, 65535)));
                10:            ins = itype(bad_ops[$urandom_range(0, 4)], rs, rt, 16'($urandom));
                default:       ins = rtype(rd, rs, rt, bad_fns[$urandom_range(0, 3)]);
            endcase
            issue(ins, ($urandom_range(0, 3) == 0));
        end
        check_regs();

        for (int w = 0; w < 64; w++) begin
            issue(itype(OP_LW, 0, 31, 16'(w * 4)), 1'b0);
        end
        check_regs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
